// File: rtl/muldiv_seq_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2^MUL_STEP shift-add multiply,
// restoring divide, accumulate ops, with a start/busy/done handshake.
module muldiv_seq_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    if ((WIDTH % MUL_STEP) != 0) begin : g_bad_step
        $error("muldiv_seq_unit: MUL_STEP must divide WIDTH");
    end

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_STEP - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    // Handshake: start is accepted only when state is IDLE, busy is low and
    // flush is low; busy stays high through the done cycle, so a start can
    // land in the cycle after done at the earliest.
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t state;

    logic [1:0]         op_q;      // funct[2:1]: 01 divide, 10 add-acc, 11 sub-acc
    logic               neg_p;     // product / quotient sign
    logic               neg_r;     // remainder sign (sign of a)
    logic               b_zero;
    logic [WIDTH-1:0]   a_q, hi_q, lo_q;
    logic [2*WIDTH-1:0] acc;       // product, or {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   opb;       // multiplier (shifted out) or divisor
    logic [CW-1:0]      cnt;

    logic               sgn, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    always_comb begin
        sgn   = ~funct[0];
        a_neg = sgn & a[WIDTH-1];
        b_neg = sgn & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    logic [2*WIDTH-1:0] mul_next;

    always_comb begin
        mul_next = acc;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (opb[j]) mul_next = mul_next + (mcand << j);
        end
    end

    logic [WIDTH:0]     div_shift, div_trial;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = div_shift - {1'b0, opb};
        div_next  = div_trial[WIDTH]
                  ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                  : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    logic [2*WIDTH-1:0] prod, mul_res, div_res, fix_res;
    logic [WIDTH-1:0]   quo_s, rem_s;

    always_comb begin
        prod    = neg_p ? -acc : acc;
        mul_res = op_q[1] ? (op_q[0] ? {hi_q, lo_q} - prod : {hi_q, lo_q} + prod)
                          : prod;
        quo_s   = neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_s   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        // INT_MIN / -1 wraps to INT_MIN with zero remainder on its own.
        div_res = b_zero ? {a_q, {WIDTH{1'b1}}} : {rem_s, quo_s};
        fix_res = (op_q == 2'b01) ? div_res : mul_res;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
            op_q   <= '0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            a_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            acc    <= '0;
            mcand  <= '0;
            opb    <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                        if (start && !busy) begin
                            busy   <= 1'b1;
                            op_q   <= funct[2:1];
                            neg_p  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            b_zero <= (b == '0);
                            a_q    <= a;
                            hi_q   <= hi_in;
                            lo_q   <= lo_in;
                            mcand  <= {{WIDTH{1'b0}}, a_mag};
                            opb    <= b_mag;
                            if (funct[2:1] == 2'b01) begin
                                state <= DIV;
                                cnt   <= DIV_LAST;
                                acc   <= {{WIDTH{1'b0}}, a_mag};
                            end else begin
                                state <= MUL;
                                cnt   <= MUL_LAST;
                                acc   <= '0;
                            end
                        end
                    end
                    MUL: begin
                        acc   <= mul_next;
                        mcand <= mcand << MUL_STEP;
                        opb   <= opb >> MUL_STEP;
                        if (cnt == '0) state <= FIX;
                        else           cnt   <= cnt - CW'(1);
                    end
                    DIV: begin
                        acc <= div_next;
                        if (cnt == '0) state <= FIX;
                        else           cnt   <= cnt - CW'(1);
                    end
                    FIX: begin
                        hi_out <= fix_res[2*WIDTH-1:WIDTH];
                        lo_out <= fix_res[WIDTH-1:0];
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Self-checking bench for muldiv_seq_unit: directed boundary ops, handshake,
// flush and reset scenarios, then random ops against an arithmetic model.
module tb_muldiv_seq_unit;

    localparam int W    = 32;
    localparam int STEP = 2;

    logic          clk = 1'b0;
    logic          reset, start, flush;
    logic [2:0]    funct;
    logic [W-1:0]  a, b, hi_in, lo_in;
    logic          busy, done;
    logic [W-1:0]  hi_out, lo_out;

    int            nvec = 0;
    int            nmis = 0;
    logic [W-1:0]  last_hi, last_lo;

    always #5 clk = ~clk;

    muldiv_seq_unit #(.WIDTH(W), .MUL_STEP(STEP)) dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct),
        .a(a), .b(b), .hi_in(hi_in), .lo_in(lo_in), .flush(flush),
        .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {HI,LO} result straight from the arithmetic rules of each funct.
    function automatic logic [63:0] model(input logic [2:0] f, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] h,
                                          input logic [31:0] l);
        logic [63:0] p;
        int          sx, sy;
        sx = x;
        sy = y;
        if (f == 3'd2) begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            return {32'(sx % sy), 32'(sx / sy)};
        end
        if (f == 3'd3) begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
        end
        if (f[0]) p = {32'h0, x} * {32'h0, y};
        else      p = 64'(longint'(sx) * longint'(sy));
        if (!f[2]) return p;
        if (f[1])  return {h, l} - p;
        return {h, l} + p;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] h, input logic [31:0] l, input bit hold,
                         input string tag);
        logic [63:0] exp;
        int          lat, exp_lat;
        bit          all_busy;
        exp     = model(f, x, y, h, l);
        exp_lat = (f[2:1] == 2'b01) ? W + 1 : W / STEP + 1;
        funct = f; a = x; b = y; hi_in = h; lo_in = l; start = 1'b1;
        tick;
        if (!hold) start = 1'b0;
        funct = 3'($urandom); a = $urandom; b = $urandom; hi_in = $urandom; lo_in = $urandom;
        lat      = 0;
        all_busy = 1'b1;
        while (!done && lat < 100) begin
            all_busy &= busy;
            tick;
            lat++;
        end
        start = 1'b0;
        all_busy &= busy;
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " busy"}, 64'(all_busy), 64'd1);
        chk({tag, " hi"}, 64'(hi_out), 64'(exp[63:32]));
        chk({tag, " lo"}, 64'(lo_out), 64'(exp[31:0]));
        last_hi = exp[63:32];
        last_lo = exp[31:0];
        tick;
        chk({tag, " done/busy after"}, 64'({done, busy}), 64'd0);
    endtask

    task automatic no_done(input int n, input string tag);
        bit seen;
        seen = 1'b0;
        repeat (n) begin
            tick;
            seen |= done;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; funct = '0;
        a = '0; b = '0; hi_in = '0; lo_in = '0;
        repeat (2) tick;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi_out), 64'd0);
        chk("reset lo", 64'(lo_out), 64'd0);
        reset = 1'b0;
        tick;

        do_op(3'd0, 32'hFFFF_FFFF, 32'd5, 32'h0, 32'h0, 1'b0, "mult -1x5");
        do_op(3'd5, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'd3, 1'b0, "maddu");
        do_op(3'd6, 32'd3, 32'd4, 32'h0, 32'd5, 1'b0, "msub");
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 1'b0, "div -7/2");
        do_op(3'd3, 32'd7, 32'd2, 32'h0, 32'h0, 1'b0, "divu 7/2");
        do_op(3'd3, 32'h1234, 32'd0, 32'h0, 32'h0, 1'b0, "divu by 0");
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, "div ovf");
        do_op(3'd2, 32'hFFFF_FFF0, 32'd0, 32'h0, 32'h0, 1'b0, "div by 0");
        do_op(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 1'b0, "mult min*min");
        do_op(3'd7, 32'h8000_0000, 32'h8000_0000, 32'h1, 32'h2, 1'b0, "msubu min*min");
        do_op(3'd4, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'h0, 1'b0, "madd neg");

        // back-to-back: second start lands in the cycle after done
        do_op(3'd1, 32'd3, 32'd4, 32'h0, 32'h0, 1'b0, "b2b multu");
        do_op(3'd3, 32'd12, 32'd5, 32'h0, 32'h0, 1'b0, "b2b divu");

        do_op(3'd1, 32'd6, 32'd7, 32'h0, 32'h0, 1'b1, "held start");
        no_done(40, "held start no second done");

        // flush during divide iteration 10
        funct = 3'd2; a = $urandom; b = 32'd3; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (10) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush div busy", 64'(busy), 64'd0);
        chk("flush div done", 64'(done), 64'd0);
        chk("flush div hi", 64'(hi_out), 64'(last_hi));
        chk("flush div lo", 64'(lo_out), 64'(last_lo));
        no_done(40, "flush div no done");

        // flush landing in the fix cycle
        funct = 3'd0; a = 32'd11; b = 32'd13; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (W / STEP) tick;
        chk("fix busy before flush", 64'(busy), 64'd1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush fix done", 64'(done), 64'd0);
        chk("flush fix busy", 64'(busy), 64'd0);
        chk("flush fix hi", 64'(hi_out), 64'(last_hi));
        chk("flush fix lo", 64'(lo_out), 64'(last_lo));
        no_done(40, "flush fix no done");

        // start and flush together in idle
        funct = 3'd1; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
        tick;
        start = 1'b0; flush = 1'b0;
        chk("start+flush busy", 64'(busy), 64'd0);
        no_done(40, "start+flush no done");

        do_op(3'd0, 32'd7, 32'd9, 32'h0, 32'h0, 1'b0, "recover mult");

        // asynchronous reset in the middle of a multiply
        funct = 3'd0; a = 32'd100; b = 32'd200; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (5) tick;
        #2 reset = 1'b1;
        #1;
        chk("async reset busy", 64'(busy), 64'd0);
        chk("async reset done", 64'(done), 64'd0);
        chk("async reset hi", 64'(hi_out), 64'd0);
        chk("async reset lo", 64'(lo_out), 64'd0);
        tick;
        reset = 1'b0;
        no_done(40, "reset no done");
        last_hi = '0;
        last_lo = '0;

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f;
            logic [31:0] x, y, h, l;
            f = 3'($urandom_range(0, 7));
            x = pick(); y = pick(); h = $urandom; l = $urandom;
            do_op(f, x, y, h, l, 1'b0, $sformatf("rand%0d f%0d", i, f));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
